// File: rtl/intc_pkg.sv
// Purpose: shared encodings for the round-robin interrupt controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package intc_pkg;

    // Handshake sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    // Default register-bus addresses
    localparam logic [3:0] DEF_ADDR_IER = 4'hC;
    localparam logic [3:0] DEF_ADDR_IPR = 4'hD;

    // Interrupt source indices
    localparam int NUM_SRC  = 4;
    localparam int SRC_OV   = 0;
    localparam int SRC_OCMP = 1;
    localparam int SRC_RX   = 2;
    localparam int SRC_TX   = 3;

endpackage

// File: rtl/intc_rr_pick4.sv
// Purpose: rotating-priority picker over four requests; search starts at last+1.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
// Ports: req[3:0] candidate set, last[1:0] previous winner,
//        valid = any candidate, idx = winning index.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the farthest position back to the nearest so the nearest
    // candidate (last+1) is the final assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = last + 2'(i + 1);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/intc_rr.sv
// Purpose: round-robin interrupt controller with irq/ack/eoi handshake and IER/IPR registers.
// Latency: source edge -> pending same edge; pending -> irq one edge later (2 cycles from edge).
// Backpressure: one interrupt outstanding; new winners wait until eoi returns the FSM to IDLE.
// Ports: clk/rst_n; register bus addr3/wen/data_in; irq_src event inputs;
//        irq_ack/eoi from the CPU; irq/irq_vec registered request; intc_mux status.
module intc_rr
    import intc_pkg::*;
#(
    parameter logic [3:0] ADDR_IER = DEF_ADDR_IER,
    parameter logic [3:0] ADDR_IPR = DEF_ADDR_IPR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] addr3,
    input  logic       wen,
    input  logic [7:0] data_in,
    input  logic [3:0] irq_src,
    input  logic       irq_ack,
    input  logic       eoi,
    output logic       irq,
    output logic [1:0] irq_vec,
    output logic [7:0] intc_mux
);

    state_t     state;
    logic [3:0] src_q;
    logic [3:0] pending;
    logic [3:0] ier;
    logic       gie;
    logic [1:0] last;

    logic [3:0] src_edge;
    logic       ier_wr;
    logic       ipr_wr;
    logic [3:0] candidates;
    logic       ack_take;
    logic [3:0] ack_clr;
    logic [3:0] w1c_clr;
    logic [3:0] pending_nxt;
    logic       pick_vld;
    logic [1:0] pick_idx;
    logic       active;
    logic       unused_data;

    // IER only uses bit 7 and bits 3:0
    assign unused_data = ^data_in[6:4];

    // src_q resets to 0, so a source already high at reset release is an edge
    assign src_edge   = irq_src & ~src_q;
    assign ier_wr     = wen && (addr3 == ADDR_IER);
    assign ipr_wr     = wen && (addr3 == ADDR_IPR);
    assign candidates = gie ? (pending & ier) : 4'b0000;

    // Ack is only honoured while a request is being presented
    assign ack_take = (state == ST_REQ) && irq_ack;
    assign ack_clr  = ack_take ? (4'b0001 << irq_vec) : 4'b0000;
    assign w1c_clr  = ipr_wr ? data_in[3:0] : 4'b0000;

    // A new edge wins over a same-cycle clear so no event is lost
    assign pending_nxt = (pending & ~(w1c_clr | ack_clr)) | src_edge;

    rr_pick4 u_pick (
        .req   (candidates),
        .last  (last),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Edge detect, pending latch and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= 4'b0000;
            pending <= 4'b0000;
            ier     <= 4'b0000;
            gie     <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= pending_nxt;
            if (ier_wr) begin
                gie <= data_in[7];
                ier <= data_in[3:0];
            end
        end
    end

    // Handshake sequencer. irq_vec is frozen from IDLE exit until the next
    // grant, so enable changes during REQ cannot retarget the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            irq     <= 1'b0;
            irq_vec <= 2'd0;
            last    <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state   <= ST_REQ;
                        irq     <= 1'b1;
                        irq_vec <= pick_idx;
                    end
                end
                ST_REQ: begin
                    // eoi in the same cycle as ack is dropped
                    if (irq_ack) begin
                        state <= ST_SERV;
                        irq   <= 1'b0;
                        last  <= irq_vec;
                    end
                end
                ST_SERV: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    assign active   = (state == ST_SERV);
    assign intc_mux = {gie, active, irq_vec, pending};

endmodule

// File: tb/tb_intc_rr.sv
// Purpose: directed self-checking bench for intc_rr with a grant-order scoreboard.
// Latency: samples outputs 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_intc_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] addr3;
    logic       wen;
    logic [7:0] data_in;
    logic [3:0] irq_src;
    logic       irq_ack;
    logic       eoi;
    logic       irq;
    logic [1:0] irq_vec;
    logic [7:0] intc_mux;

    int checks = 0;
    int passed = 0;

    // Expected grant order, pushed when the stimulus creates the events
    logic [1:0] sb[$];

    intc_rr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr3    (addr3),
        .wen      (wen),
        .data_in  (data_in),
        .irq_src  (irq_src),
        .irq_ack  (irq_ack),
        .eoi      (eoi),
        .irq      (irq),
        .irq_vec  (irq_vec),
        .intc_mux (intc_mux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wen     = 1'b1;
        addr3   = a;
        data_in = d;
        tick();
        wen     = 1'b0;
        addr3   = 4'h0;
        data_in = 8'h00;
    endtask

    task automatic pop_chk(input string tag);
        logic [1:0] exp_v;
        exp_v = 2'bxx;
        if (sb.size() > 0) exp_v = sb.pop_front();
        chk({tag, "_vec"}, 8'(irq_vec), 8'(exp_v));
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_irq"}, 8'(irq), 8'h01);
        pop_chk(tag);
    endtask

    task automatic ack_eoi();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        eoi     = 1'b1;
        tick();
        eoi     = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        addr3   = 4'h0;
        wen     = 1'b0;
        data_in = 8'h00;
        irq_src = 4'h0;
        irq_ack = 1'b0;
        eoi     = 1'b0;
        repeat (2) tick();
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_vec", 8'(irq_vec), 8'h00);
        chk("rst_mux", intc_mux, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single source, exact 2-cycle latency, ack and eoi
        wr(4'hC, 8'h81);
        chk("ier_mux", intc_mux, 8'h80);
        irq_src = 4'b0001;
        sb.push_back(2'd0);
        tick();
        irq_src = 4'b0000;
        chk("lat1_irq", 8'(irq), 8'h00);
        chk("lat1_mux", intc_mux, 8'h81);
        tick();
        chk("lat2_irq", 8'(irq), 8'h01);
        pop_chk("lat2");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_irq", 8'(irq), 8'h00);
        chk("ack_mux", intc_mux, 8'hC0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("eoi_mux", intc_mux, 8'h80);

        // Reset in SERV with pending=0110
        irq_src = 4'b0111;
        sb.push_back(2'd0);
        tick();
        irq_src = 4'b0000;
        wait_irq("ms");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("serv_mux", intc_mux, 8'hC6);
        rst_n = 1'b0;
        tick();
        chk("msrst_mux", intc_mux, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("msrel_irq", 8'(irq), 8'h00);
        chk("msrel_mux", intc_mux, 8'h00);
        wr(4'hC, 8'h8F);
        repeat (3) tick();
        chk("noedge_irq", 8'(irq), 8'h00);
        chk("noedge_mux", intc_mux, 8'h80);

        // Rotation: 0 and 2 together from last=3, then 0 and 3 from last=2
        irq_src = 4'b0101;
        sb.push_back(2'd0);
        sb.push_back(2'd2);
        tick();
        irq_src = 4'b0000;
        wait_irq("rr_a0");
        ack_eoi();
        wait_irq("rr_a2");
        ack_eoi();
        irq_src = 4'b1001;
        sb.push_back(2'd3);
        sb.push_back(2'd0);
        tick();
        irq_src = 4'b0000;
        wait_irq("rr_b3");
        ack_eoi();
        wait_irq("rr_b0");
        ack_eoi();
        chk("rr_end_mux", intc_mux, 8'h80);

        // GIE off: pending latches, no request; W1C clears it
        wr(4'hC, 8'h04);
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        repeat (3) tick();
        chk("gie0_irq", 8'(irq), 8'h00);
        chk("gie0_mux", intc_mux, 8'h04);
        wr(4'hD, 8'h04);
        chk("w1c_mux", intc_mux, 8'h00);

        // W1C colliding with a new edge on the same bit
        wen     = 1'b1;
        addr3   = 4'hD;
        data_in = 8'h02;
        irq_src = 4'b0010;
        tick();
        wen     = 1'b0;
        addr3   = 4'h0;
        data_in = 8'h00;
        irq_src = 4'b0000;
        chk("setclr_mux", intc_mux, 8'h02);
        wr(4'hD, 8'h02);
        chk("clr1_mux", intc_mux, 8'h00);

        // Handshake filtering
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("idle_ack_irq", 8'(irq), 8'h00);
        chk("idle_ack_mux", intc_mux, 8'h00);
        wr(4'hC, 8'h82);
        irq_src = 4'b0010;
        sb.push_back(2'd1);
        tick();
        irq_src = 4'b0000;
        wait_irq("filt");
        chk("req_mux", intc_mux, 8'h92);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("req_eoi_irq", 8'(irq), 8'h01);
        chk("req_eoi_mux", intc_mux, 8'h92);
        wr(4'hC, 8'h00);
        chk("req_ier0_irq", 8'(irq), 8'h01);
        chk("req_ier0_mux", intc_mux, 8'h12);
        irq_ack = 1'b1;
        eoi     = 1'b1;
        tick();
        irq_ack = 1'b0;
        eoi     = 1'b0;
        chk("acketc_irq", 8'(irq), 8'h00);
        chk("acketc_mux", intc_mux, 8'h50);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("final_mux", intc_mux, 8'h10);
        chk("sb_empty", 8'(sb.size()), 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
